// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: the raw PS/2 lines and rx_en go in, and the received byte and status pulses come out.
// The master side is the environment; the slave side is the receiver.
`timescale 1ns/1ps
interface ps2_rx_if;
  logic       ps2c;
  logic       ps2d;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  modport master (
    output ps2c, ps2d, rx_en,
    input  dout, rx_done_tick, frame_err
  );

  modport slave (
    input  ps2c, ps2d, rx_en,
    output dout, rx_done_tick, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver with a glitch-filtered clock and a stalled-frame timeout.
// Define PS2_PARITY_CHECK_EN to reject frames that fail the odd-parity check.
`timescale 1ns/1ps
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic    clk,
  input  logic    reset,
  ps2_rx_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t                state_q, state_d;
  logic                  ps2c_meta_q, ps2c_sync_q;
  logic                  ps2d_meta_q, ps2d_sync_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  fall;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]         idle_cnt_q, idle_cnt_d, idle_inc;
  logic [9:0]            shreg_q, shreg_d;
  logic [7:0]            dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  frame_ok;

  // The filter history and level start at 1 so that leaving reset cannot look like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shreg_q     <= '0;
      dout_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ps2c_meta_q <= bus.ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= bus.ps2d;
      ps2d_sync_q <= ps2d_meta_q;
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      shreg_q     <= shreg_d;
      dout_q      <= dout_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], ps2c_sync_q};
    filt_d = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end
    fall = filt_q & ~filt_d;
  end

  // The status pulses are registered on the edge that enters LOAD, so they are visible during LOAD itself.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    frame_ok   = 1'b0;
    idle_inc   = idle_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (fall && bus.rx_en && !ps2d_sync_q) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd10;
        end
      end
      SHIFT: begin
        if (fall) begin
          shreg_d    = {ps2d_sync_q, shreg_q[9:1]};
          bit_cnt_d  = bit_cnt_q - 1'b1;
          idle_cnt_d = '0;
          if (bit_cnt_q == 4'd1) begin
            state_d = LOAD;
`ifdef PS2_PARITY_CHECK_EN
            frame_ok = shreg_d[9] & (^shreg_d[8:0]);
`else
            frame_ok = shreg_d[9];
`endif
            if (frame_ok) begin
              dout_d = shreg_d[7:0];
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (idle_inc == TW'(TIMEOUT - 1)) begin
          state_d    = IDLE;
          idle_cnt_d = '0;
          err_d      = 1'b1;
        end else begin
          idle_cnt_d = idle_inc;
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = err_q;
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive equal synchronized ps2c samples required to change the filtered clock level (range 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the number of clk cycles without a ps2c falling edge after which a frame in progress is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2c  input  1  asynchronous PS/2 clock line, idle high.
REQ-006 SHALL have port ps2d  input  1  asynchronous PS/2 data line, idle high.
REQ-007 SHALL have port rx_en  input  1  enables acceptance of new frames.
REQ-008 SHALL have port dout  output  8  last correctly received scan-code byte.
REQ-009 SHALL have port rx_done_tick  output  1  one-cycle pulse: dout was updated in this cycle.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: a frame was rejected or abandoned.

Function
REQ-011 SHALL pass ps2c and ps2d through two-flop synchronizers before any use.
REQ-012 SHALL set the filtered clock to 1 when the last FILTER_LEN synchronized ps2c samples are all 1, to 0 when they are all 0, and SHALL otherwise hold it.
REQ-013 SHALL generate an internal fall pulse for exactly one cycle when the filtered clock changes from 1 to 0.
REQ-014 SHALL implement states IDLE, SHIFT and LOAD.
REQ-015 IDLE: on fall with rx_en=1 and synchronized ps2d=0 (start bit) -> SHIFT, bit counter set to 10; on fall with ps2d=1 or rx_en=0 -> stay IDLE, no output activity.
REQ-016 SHIFT: on each fall, shift synchronized ps2d into a 10-bit register from the MSB side (LSB-first frame) and decrement the counter; on the fall that brings the counter to 0 -> LOAD.
REQ-017 After SHIFT, register bits [7:0] SHALL hold data, bit [8] parity, bit [9] stop.
REQ-018 LOAD lasts one cycle, then -> IDLE unconditionally.
REQ-019 In LOAD, if the frame is valid, dout SHALL take data bits [7:0] and rx_done_tick SHALL be 1 in that same cycle; otherwise frame_err SHALL be 1 and dout SHALL hold.
REQ-020 A frame SHALL be valid when stop=1 (plus the parity rule of REQ-031 when enabled).
REQ-021 rx_done_tick SHALL assert exactly one clk cycle after the cycle in which the stop-bit fall is sampled.
REQ-022 In SHIFT, an idle counter SHALL clear on every fall and increment otherwise; on reaching TIMEOUT-1 -> IDLE with frame_err=1 for one cycle, dout unchanged.
REQ-023 Deasserting rx_en during SHIFT or LOAD SHALL NOT abort the frame; rx_en is sampled only in IDLE.
REQ-024 rx_done_tick and frame_err SHALL never be 1 in the same cycle, and neither SHALL stay high for more than one cycle.
REQ-025 dout SHALL change only in a cycle where rx_done_tick=1.

Reset
REQ-026 Reset SHALL force state IDLE, counters 0, shift register 0, dout=8'h00, rx_done_tick=0 and frame_err=0.
REQ-027 Reset SHALL preset the filter history and filtered clock to 1 so that release of reset never generates a spurious fall.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame with no rx_done_tick or frame_err pulse.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN SHALL select parity checking.
REQ-030 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored for validity.
REQ-031 With PS2_PARITY_CHECK_EN, a frame SHALL be valid only if data bits [7:0] plus the parity bit contain an odd number of ones; otherwise the frame is rejected per REQ-019.

Verification (ps2c half-period 40 clk, FILTER_LEN=8, TIMEOUT=2000)
REQ-032 Frame 0xF0 with parity=1, stop=1, rx_en=1 -> single rx_done_tick, dout=8'hF0, frame_err stays 0.
REQ-033 Back-to-back frames 0xF0 then 0x1C (parity 0) -> two rx_done_ticks; dout=8'hF0, then 8'h1C.
REQ-034 Frame 0x1C with parity=1 -> with the macro: frame_err pulse, dout unchanged; without the macro: dout=8'h1C.
REQ-035 Frame 0x1C with stop=0 -> frame_err pulse, no rx_done_tick, dout unchanged.
REQ-036 Frame stopped after 4 data bits, ps2c held high -> frame_err pulse 2000 cycles after the last fall; the following frame 0x1C is received correctly.
REQ-037 1-5 cycle glitches on ps2c while idle, and rx_en=0 during a full frame -> no fall accepted, no output pulses; reset during bit 5 -> no pulses, dout=8'h00.
